axis_burst_arbiter: RTL and testbench

Round-robin, burst-granular arbiter that shares one downstream AXI-stream datapath (the zero-pad/upsample stage feeding peak detection) between NUM_CH per-antenna sample streams. A channel holds the grant for a whole burst, up to and including its tlast beat. The source channel index travels with each beat on tuser. Runaway bursts longer than MAX_BURST are cut with a forced tlast, and the rest of that burst is drained.

---
 rtl/axis_burst_arbiter_if.sv | 30 +++
 rtl/axis_burst_arbiter.sv | 110 +++++++++++
 tb/tb_axis_burst_arbiter.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/axis_burst_arbiter_if.sv
// axis_burst_arbiter_if: bundle of the NUM_CH upstream streams and the merged downstream stream
//   s_axis_tvalid/tdata/tlast  per-channel upstream beats (channel k in tdata[32k+31:32k])
//   s_axis_tready              per-channel ready, driven by the arbiter
//   m_axis_tvalid/tdata/tlast  merged output stream
//   m_axis_tuser               source channel index of the output beat
//   m_axis_tready              downstream ready
//   modport slave  : the arbiter's view
//   modport master : the surrounding sources and sink
interface axis_burst_arbiter_if #(
   parameter int NUM_CH   = 4,
   parameter int ID_WIDTH = 2
);
   logic [NUM_CH-1:0]    s_axis_tvalid;
   logic [NUM_CH-1:0]    s_axis_tready;
   logic [32*NUM_CH-1:0] s_axis_tdata;
   logic [NUM_CH-1:0]    s_axis_tlast;
   logic                 m_axis_tvalid;
   logic                 m_axis_tready;
   logic [31:0]          m_axis_tdata;
   logic                 m_axis_tlast;
   logic [ID_WIDTH-1:0]  m_axis_tuser;
   modport slave (
      input  s_axis_tvalid, s_axis_tdata, s_axis_tlast, m_axis_tready,
      output s_axis_tready, m_axis_tvalid, m_axis_tdata, m_axis_tlast, m_axis_tuser
   );
   modport master (
      output s_axis_tvalid, s_axis_tdata, s_axis_tlast, m_axis_tready,
      input  s_axis_tready, m_axis_tvalid, m_axis_tdata, m_axis_tlast, m_axis_tuser
   );
endinterface

// File: rtl/axis_burst_arbiter.sv
// axis_burst_arbiter: round-robin, burst-granular arbiter merging NUM_CH AXI streams into one
//   clk           single clock
//   rst_n         asynchronous active-low reset
//   bus           slave view of axis_burst_arbiter_if (s_axis_* in, m_axis_* out, tuser = source)
//   overflow      sticky, set whenever a runaway burst is cut with a forced tlast
//   clr_overflow  synchronous clear of overflow (set wins on collision)
//   busy          high in any state other than IDLE
module axis_burst_arbiter #(
   parameter int NUM_CH     = 4,
   parameter int MAX_BURST  = 1024,
   localparam int ID_WIDTH  = NUM_CH > 1 ? $clog2(NUM_CH) : 1,
   localparam int CNT_WIDTH = $clog2(MAX_BURST)
) (
   input  logic                clk,
   input  logic                rst_n,
   axis_burst_arbiter_if.slave bus,
   output logic                overflow,
   input  logic                clr_overflow,
   output logic                busy
);
   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] BURST = 2'd1;
   localparam logic [1:0] DRAIN = 2'd2;
   logic [1:0]           state_q, state_d;
   logic [ID_WIDTH-1:0]  grant_q, grant_d, last_q, last_d, pick, idx;
   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
   logic                 m_valid_q, m_valid_d, m_last_q, m_last_d, ovf_q, ovf_d;
   logic [31:0]          m_data_q, m_data_d, sel_data;
   logic [ID_WIDTH-1:0]  m_user_q, m_user_d;
   logic [NUM_CH-1:0]    gnt_oh;
   logic                 found, load_ok, acc, sel_last, load, cut;
   // search upward from the previous winner so every requester is served in turn
   always_comb begin
      found = 1'b0;
      pick  = last_q;
      idx   = last_q;
      for (int i = 1; i <= NUM_CH; i++) begin
         idx = ID_WIDTH'((int'(last_q) + i) % NUM_CH);
         if (!found && bus.s_axis_tvalid[idx]) begin
            found = 1'b1;
            pick  = idx;
         end
      end
   end
   always_comb begin
      sel_data = '0;
      for (int k = 0; k < NUM_CH; k++)
         if (grant_q == ID_WIDTH'(k)) sel_data = bus.s_axis_tdata[32*k +: 32];
   end
   assign gnt_oh   = NUM_CH'(1) << grant_q;
   assign load_ok  = !m_valid_q || bus.m_axis_tready;
   // DRAIN accepts unconditionally because its beats are thrown away
   assign bus.s_axis_tready = (state_q == DRAIN || (state_q == BURST && load_ok)) ? gnt_oh : '0;
   assign acc      = |(bus.s_axis_tvalid & bus.s_axis_tready);
   assign sel_last = |(bus.s_axis_tlast & gnt_oh);
   assign load     = state_q == BURST && acc;
   assign cut      = load && !sel_last && cnt_q == CNT_WIDTH'(MAX_BURST - 1);
   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      last_d  = last_q;
      cnt_d   = cnt_q;
      if (state_q == IDLE && found) begin
         state_d = BURST;
         grant_d = pick;
         cnt_d   = '0;
      end
      if (load) cnt_d = cnt_q + CNT_WIDTH'(1);
      if (acc && sel_last) begin
         state_d = IDLE;
         last_d  = grant_q;
      end else if (cut) begin
         state_d = DRAIN;
      end
      m_valid_d = load ? 1'b1 : bus.m_axis_tready ? 1'b0 : m_valid_q;
      m_data_d  = load ? sel_data : m_data_q;
      m_last_d  = load ? (sel_last || cut) : m_last_q;
      m_user_d  = load ? grant_q : m_user_q;
      ovf_d     = cut ? 1'b1 : clr_overflow ? 1'b0 : ovf_q;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         grant_q   <= '0;
         last_q    <= ID_WIDTH'(NUM_CH - 1);
         cnt_q     <= '0;
         m_valid_q <= 1'b0;
         m_data_q  <= '0;
         m_last_q  <= 1'b0;
         m_user_q  <= '0;
         ovf_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         grant_q   <= grant_d;
         last_q    <= last_d;
         cnt_q     <= cnt_d;
         m_valid_q <= m_valid_d;
         m_data_q  <= m_data_d;
         m_last_q  <= m_last_d;
         m_user_q  <= m_user_d;
         ovf_q     <= ovf_d;
      end
   end
   assign bus.m_axis_tvalid = m_valid_q;
   assign bus.m_axis_tdata  = m_data_q;
   assign bus.m_axis_tlast  = m_last_q;
   assign bus.m_axis_tuser  = m_user_q;
   assign overflow          = ovf_q;
   assign busy              = state_q != IDLE;
endmodule

// File: tb/tb_axis_burst_arbiter.sv
// tb_axis_burst_arbiter: scenario table plus scoreboard for the burst arbiter
module tb_axis_burst_arbiter;
   localparam int NUM_CH    = 4;
   localparam int MAX_BURST = 8;
   localparam int IDW       = 2;
   typedef struct packed {
      logic [31:0]    data;
      logic           last;
      logic [IDW-1:0] user;
   } beat_t;
   typedef struct {
      logic [NUM_CH-1:0] mask;
      int                len;
      int                nb;
      int                mode;
      int                exp_beats;
      logic              exp_ovf;
   } vec_t;
   logic clk = 1'b0, rst_n = 1'b1, clr_overflow = 1'b0, overflow, busy;
   int   n_tests = 0, n_fail = 0, rdy_mode = 0, n_out = 0, scen = 0, model_last = NUM_CH - 1;
   bit   chk_gap = 1'b0;
   beat_t exp_q[$];
   logic [32:0] src_q[NUM_CH][$];
   logic [NUM_CH-1:0] hs_s;
   beat_t held, cur, e;
   bit    was_held = 1'b0, have_prev = 1'b0, prev_last = 1'b0;
   int    idle_run = 0, pat = 0;
   vec_t  vecs[9];
   always #5 clk = ~clk;
   axis_burst_arbiter_if #(.NUM_CH(NUM_CH), .ID_WIDTH(IDW)) bus ();
   axis_burst_arbiter #(.NUM_CH(NUM_CH), .MAX_BURST(MAX_BURST)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus),
      .overflow(overflow), .clr_overflow(clr_overflow), .busy(busy)
   );
   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask
   function automatic logic [31:0] mkdata(input int k, input int b, input int i);
      return {8'(scen), 8'(k), 8'(b), 8'(i)};
   endfunction
   function automatic int src_left();
      int s = 0;
      for (int k = 0; k < NUM_CH; k++) s += src_q[k].size();
      return s;
   endfunction
   // sources present the head of their queue; sink ready follows rdy_mode
   initial begin
      bus.s_axis_tvalid = '0;
      bus.s_axis_tdata  = '0;
      bus.s_axis_tlast  = '0;
      bus.m_axis_tready = 1'b0;
      forever begin
         @(negedge clk);
         hs_s = bus.s_axis_tvalid & bus.s_axis_tready;
         @(posedge clk);
         #1;
         for (int k = 0; k < NUM_CH; k++) begin
            if (hs_s[k] && src_q[k].size() > 0) src_q[k].delete(0);
            if (src_q[k].size() > 0) begin
               bus.s_axis_tvalid[k]         = 1'b1;
               bus.s_axis_tdata[32*k +: 32] = src_q[k][0][31:0];
               bus.s_axis_tlast[k]          = src_q[k][0][32];
            end else begin
               bus.s_axis_tvalid[k]         = 1'b0;
               bus.s_axis_tdata[32*k +: 32] = 32'h0;
               bus.s_axis_tlast[k]          = 1'b0;
            end
         end
         pat++;
         bus.m_axis_tready = rdy_mode == 0 ? 1'b1 :
                             rdy_mode == 1 ? (pat % 4 == 0 || pat % 4 == 3) :
                             rdy_mode == 2 ? 1'($urandom_range(0, 1)) : 1'b0;
      end
   end
   // output monitor: scoreboard pop, hold stability, one-hot ready, burst gap
   initial begin
      forever begin
         @(negedge clk);
         cur = {bus.m_axis_tdata, bus.m_axis_tlast, bus.m_axis_tuser};
         if (!rst_n) begin
            was_held  = 1'b0;
            have_prev = 1'b0;
         end else begin
            check("s_ready_onehot", $countones(bus.s_axis_tready) <= 1, 1);
            if (was_held) begin
               check("hold_valid", bus.m_axis_tvalid, 1);
               check("hold_stable", cur, held);
            end
            if (!chk_gap) have_prev = 1'b0;
            if (bus.m_axis_tvalid && bus.m_axis_tready) begin
               n_out++;
               if (exp_q.size() == 0) begin
                  n_tests++;
                  n_fail++;
                  $display("FAIL unexpected_beat: got %0h, expected none", cur);
               end else begin
                  e = exp_q.pop_front();
                  check("beat_data", cur.data, e.data);
                  check("beat_last", cur.last, e.last);
                  check("beat_user", cur.user, e.user);
               end
               if (have_prev) check("beat_gap", idle_run, prev_last ? 1 : 0);
               have_prev = chk_gap;
               prev_last = cur.last;
               idle_run  = 0;
            end else if (!bus.m_axis_tvalid) begin
               idle_run++;
            end
            was_held = bus.m_axis_tvalid && !bus.m_axis_tready;
            held     = cur;
         end
      end
   end
   task automatic run(input vec_t v);
      int pend[NUM_CH];
      int start, waited;
      scen++;
      rdy_mode = v.mode;
      chk_gap  = v.mode == 0 && !v.exp_ovf;
      start    = n_out;
      @(posedge clk);
      #2;
      for (int k = 0; k < NUM_CH; k++) begin
         pend[k] = v.mask[k] ? v.nb : 0;
         for (int b = 0; b < pend[k]; b++)
            for (int i = 0; i < v.len; i++)
               src_q[k].push_back({i == v.len - 1, mkdata(k, b, i)});
      end
      for (int n = 0; n < NUM_CH * v.nb; n++) begin
         int w;
         w = -1;
         for (int j = 1; j <= NUM_CH; j++)
            if (w < 0 && pend[(model_last + j) % NUM_CH] > 0) w = (model_last + j) % NUM_CH;
         if (w >= 0) begin
            for (int i = 0; i < v.len && i < MAX_BURST; i++)
               exp_q.push_back('{mkdata(w, v.nb - pend[w], i),
                                 (i == v.len - 1) || (i == MAX_BURST - 1), IDW'(w)});
            pend[w]--;
            model_last = w;
         end
      end
      waited = 0;
      while ((exp_q.size() > 0 || busy || src_left() > 0) && waited < 400) begin
         @(negedge clk);
         waited++;
      end
      check("scen_done", waited < 400, 1);
      @(negedge clk);
      check("scen_beats", n_out - start, v.exp_beats);
      check("scen_overflow", overflow, v.exp_ovf);
      chk_gap = 1'b0;
      @(posedge clk);
      #1;
      clr_overflow = 1'b1;
      @(posedge clk);
      #1;
      clr_overflow = 1'b0;
      check("overflow_clr", overflow, 0);
   endtask
   initial begin
      int waited;
      vecs[0] = '{4'b0101,  3, 1, 0,  6, 1'b0};
      vecs[1] = '{4'b1111,  2, 2, 0, 16, 1'b0};
      vecs[2] = '{4'b0010,  1, 1, 1,  1, 1'b0};
      vecs[3] = '{4'b1000, 12, 1, 0,  8, 1'b1};
      vecs[4] = '{4'b0001,  8, 1, 0,  8, 1'b0};
      vecs[5] = '{4'b1111,  5, 1, 2, 20, 1'b0};
      vecs[6] = '{4'b0110,  9, 1, 2, 16, 1'b1};
      vecs[7] = '{4'b1001,  7, 2, 1, 28, 1'b0};
      vecs[8] = '{4'b0011,  2, 1, 0,  4, 1'b0};
      #1;
      rst_n = 1'b0;
      #1;
      check("rst_m_valid", bus.m_axis_tvalid, 0);
      check("rst_s_ready", bus.s_axis_tready, 0);
      check("rst_m_data", bus.m_axis_tdata, 0);
      check("rst_m_last", bus.m_axis_tlast, 0);
      check("rst_m_user", bus.m_axis_tuser, 0);
      check("rst_overflow", overflow, 0);
      check("rst_busy", busy, 0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      for (int v = 0; v < 8; v++) run(vecs[v]);
      scen++;
      rdy_mode = 3;
      @(posedge clk);
      #2;
      for (int i = 0; i < 6; i++) src_q[0].push_back({i == 5, mkdata(0, 0, i)});
      waited = 0;
      while (!bus.m_axis_tvalid && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      check("arst_fill_valid", bus.m_axis_tvalid, 1);
      check("arst_fill_busy", busy, 1);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_m_valid", bus.m_axis_tvalid, 0);
      check("arst_s_ready", bus.s_axis_tready, 0);
      check("arst_busy", busy, 0);
      check("arst_m_data", bus.m_axis_tdata, 0);
      src_q[0].delete();
      exp_q.delete();
      model_last = NUM_CH - 1;
      rdy_mode   = 0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      run(vecs[8]);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
